// File: rtl/temp_frame_buffer.sv
// Ping-pong temperature buffer: the sampler fills one bank while the request stage
// reads the other; banks swap only when the reader signals a frame boundary.
module temp_frame_buffer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrStart,
    input  logic              wrValid,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic              rdSwap,
    input  logic              clrErr,
    output logic [DATA_W-1:0] rdData,
    output logic              rdBank,
    output logic              dataValid,
    output logic              pending,
    output logic              wrBusy,
    output logic              errOvf,
    output logic              errShort
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              pending_q, pending_d;
    logic              rdBank_q, rdBank_d;
    logic              dataValid_q, dataValid_d;
    logic              errOvf_q, errOvf_d;
    logic              errShort_q, errShort_d;
    logic [DATA_W-1:0] rdData_q;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              ovf_evt;
    logic              short_evt;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pending_d = pending_q;
        we        = 1'b0;
        waddr     = ptr_q;
        ovf_evt   = 1'b0;
        short_evt = 1'b0;

        if (wrStart) begin
            // A restart in FILL behaves exactly like a fresh start from IDLE.
            short_evt = (state_q == ST_FILL);
            state_d   = ST_FILL;
            pending_d = 1'b0;
            if (wrValid) begin
                we    = 1'b1;
                waddr = '0;
                ptr_d = ADDR_W'(1);
            end else begin
                ptr_d = '0;
            end
        end else if (wrValid) begin
            if (state_q == ST_IDLE) begin
                ovf_evt = 1'b1;
            end else begin
                we = 1'b1;
                if (ptr_q == '1) begin
                    ptr_d     = '0;
                    state_d   = ST_IDLE;
                    pending_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
        end

        rdBank_d    = rdBank_q;
        dataValid_d = dataValid_q;
        // pending_q is only ever set in IDLE, so a swap never races a completing write.
        if (rdSwap && pending_q) begin
            rdBank_d    = ~rdBank_q;
            pending_d   = 1'b0;
            dataValid_d = 1'b1;
        end

        errOvf_d   = (errOvf_q & ~clrErr) | ovf_evt;
        errShort_d = (errShort_q & ~clrErr) | short_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            pending_q   <= 1'b0;
            rdBank_q    <= 1'b0;
            dataValid_q <= 1'b0;
            errOvf_q    <= 1'b0;
            errShort_q  <= 1'b0;
            rdData_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pending_q   <= pending_d;
            rdBank_q    <= rdBank_d;
            dataValid_q <= dataValid_d;
            errOvf_q    <= errOvf_d;
            errShort_q  <= errShort_d;
            rdData_q    <= mem[{rdBank_q, rdAddr}];
        end
    end

    // Storage is intentionally not reset; the write bank is always the one not being read.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[{~rdBank_q, waddr}] <= wrData;
        end
    end

    assign rdData    = rdData_q;
    assign rdBank    = rdBank_q;
    assign dataValid = dataValid_q;
    assign pending   = pending_q;
    assign wrBusy    = (state_q == ST_FILL);
    assign errOvf    = errOvf_q;
    assign errShort  = errShort_q;

endmodule

// File: tb/tb_temp_frame_buffer.sv
// Directed bench for temp_frame_buffer: captures, swaps, error flags and reset.
module tb_temp_frame_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrStart, wrValid, rdSwap, clrErr;
    logic [7:0] wrData;
    logic [6:0] rdAddr;
    logic [7:0] rdData;
    logic       rdBank, dataValid, pending, wrBusy, errOvf, errShort;

    int unsigned total = 0;
    int unsigned bad   = 0;

    temp_frame_buffer #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .wrStart(wrStart), .wrValid(wrValid), .wrData(wrData),
        .rdAddr(rdAddr), .rdSwap(rdSwap), .clrErr(clrErr), .rdData(rdData),
        .rdBank(rdBank), .dataValid(dataValid), .pending(pending), .wrBusy(wrBusy),
        .errOvf(errOvf), .errShort(errShort)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 128-byte capture of base+i; leaves wrValid low afterwards.
    task automatic capture(input logic [7:0] base);
        for (int i = 0; i < 128; i++) begin
            wrStart = (i == 0);
            wrValid = 1'b1;
            wrData  = base + 8'(i);
            tick();
        end
        wrStart = 1'b0;
        wrValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wrStart = 0; wrValid = 0; wrData = '0; rdAddr = '0; rdSwap = 0; clrErr = 0;
        tick(); tick();
        total++; if ({rdData, rdBank, dataValid, pending, wrBusy, errOvf, errShort} !== 14'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {rdData, rdBank, dataValid, pending, wrBusy, errOvf, errShort}); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        wrStart = 1; wrValid = 1; wrData = 8'h00; tick();
        total++; if (wrBusy !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b exp=1", wrBusy); end
        for (int i = 1; i < 128; i++) begin
            wrStart = 0; wrData = 8'(i); tick();
        end
        wrValid = 0;
        total++; if ({pending, wrBusy} !== 2'b10) begin bad++; $display("FAIL basic_done pend/busy got=%b exp=10", {pending, wrBusy}); end
        rdSwap = 1; tick(); rdSwap = 0;
        total++; if ({rdBank, dataValid, pending} !== 3'b110) begin bad++; $display("FAIL basic_swap bank/valid/pend got=%b exp=110", {rdBank, dataValid, pending}); end
        rdAddr = 7'h05; tick();
        total++; if (rdData !== 8'h05) begin bad++; $display("FAIL basic_read got=%h exp=05", rdData); end
    endtask

    task automatic test_second_capture();
        int unsigned errs = 0;
        for (int i = 0; i < 128; i++) begin
            wrStart = (i == 0); wrValid = 1; wrData = 8'h80 + 8'(i); rdAddr = 7'(127 - i);
            tick();
            if (rdData !== 8'(127 - i)) errs++;
        end
        wrStart = 0; wrValid = 0;
        total++; if (errs != 0) begin bad++; $display("FAIL sweep_during_capture bad_reads=%0d exp=0", errs); end
        total++; if ({rdBank, pending} !== 2'b11) begin bad++; $display("FAIL second_pending bank/pend got=%b exp=11", {rdBank, pending}); end
        rdAddr = 7'h05; rdSwap = 1; tick(); rdSwap = 0;
        total++; if (rdData !== 8'h05) begin bad++; $display("FAIL read_in_swap_cycle got=%h exp=05", rdData); end
        total++; if (rdBank !== 1'b0) begin bad++; $display("FAIL second_swap_bank got=%b exp=0", rdBank); end
        tick();
        total++; if (rdData !== 8'h85) begin bad++; $display("FAIL second_read got=%h exp=85", rdData); end
    endtask

    task automatic test_swap_ignored();
        rdSwap = 1; tick(); rdSwap = 0;
        total++; if (rdBank !== 1'b0) begin bad++; $display("FAIL swap_no_pending got=%b exp=0", rdBank); end
        for (int i = 0; i < 128; i++) begin
            wrStart = (i == 0); wrValid = 1; wrData = 8'h20 + 8'(i); rdSwap = (i == 127);
            tick();
        end
        wrStart = 0; wrValid = 0; rdSwap = 0;
        total++; if ({rdBank, pending} !== 2'b01) begin bad++; $display("FAIL swap_final_write bank/pend got=%b exp=01", {rdBank, pending}); end
        rdSwap = 1; tick(); rdSwap = 0;
        rdAddr = 7'h10; tick();
        total++; if ({rdBank, rdData} !== {1'b1, 8'h30}) begin bad++; $display("FAIL swap_after_ignored bank/data got=%h exp=130", {rdBank, rdData}); end
    endtask

    task automatic test_short();
        for (int i = 0; i < 40; i++) begin
            wrStart = (i == 0); wrValid = 1; wrData = 8'hA0 + 8'(i); tick();
        end
        total++; if (errShort !== 1'b0) begin bad++; $display("FAIL short_before_restart got=%b exp=0", errShort); end
        wrStart = 1; wrData = 8'h11; tick();
        total++; if ({errShort, wrBusy, pending} !== 3'b110) begin bad++; $display("FAIL short_restart flag/busy/pend got=%b exp=110", {errShort, wrBusy, pending}); end
        for (int i = 1; i < 128; i++) begin
            wrStart = 0; wrData = 8'h11 + 8'(i); tick();
        end
        wrValid = 0;
        rdSwap = 1; tick(); rdSwap = 0;
        rdAddr = 7'h00; tick();
        total++; if ({rdBank, rdData} !== {1'b0, 8'h11}) begin bad++; $display("FAIL short_addr0 bank/data got=%h exp=011", {rdBank, rdData}); end
        rdAddr = 7'h7F; tick();
        total++; if (rdData !== 8'h90) begin bad++; $display("FAIL short_addr7f got=%h exp=90", rdData); end
    endtask

    task automatic test_ovf();
        clrErr = 1; tick(); clrErr = 0;
        total++; if ({errShort, errOvf} !== 2'b00) begin bad++; $display("FAIL clr_short got=%b exp=00", {errShort, errOvf}); end
        wrValid = 1; wrData = 8'hEE; tick(); wrValid = 0;
        total++; if ({errOvf, wrBusy, pending} !== 3'b100) begin bad++; $display("FAIL ovf_idle flag/busy/pend got=%b exp=100", {errOvf, wrBusy, pending}); end
        rdAddr = 7'h00; tick();
        total++; if (rdData !== 8'h11) begin bad++; $display("FAIL ovf_read_bank got=%h exp=11", rdData); end
        clrErr = 1; wrValid = 1; tick(); clrErr = 0; wrValid = 0;
        total++; if (errOvf !== 1'b1) begin bad++; $display("FAIL ovf_clr_collision got=%b exp=1", errOvf); end
        clrErr = 1; tick(); clrErr = 0;
        total++; if (errOvf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", errOvf); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            wrStart = (i == 0); wrValid = 1; wrData = 8'hC0 + 8'(i); tick();
        end
        wrStart = 0; wrValid = 0;
        clrErr = 0; wrValid = 1; tick(); wrValid = 0; // keep FILL, no new error
        total++; if (wrBusy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", wrBusy); end
        rst = 1; wrValid = 1; tick(); rst = 0; wrValid = 0;
        total++; if ({rdData, rdBank, dataValid, pending, wrBusy, errOvf, errShort} !== 14'd0) begin
            bad++; $display("FAIL mid_reset_outputs got=%h exp=0", {rdData, rdBank, dataValid, pending, wrBusy, errOvf, errShort}); end
        capture(8'h40);
        rdSwap = 1; tick(); rdSwap = 0;
        rdAddr = 7'h03; tick();
        total++; if ({rdBank, dataValid, rdData} !== {2'b11, 8'h43}) begin bad++; $display("FAIL after_reset bank/valid/data got=%h exp=343", {rdBank, dataValid, rdData}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second_capture();
        test_swap_ignored();
        test_short();
        test_ovf();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/temp_frame_buffer.md
# temp_frame_buffer

Ping-pong temperature buffer between the sensor sampling stage and the temperature request stage that builds the telemetry frame. The sampler streams 128 temperature bytes per capture into the write bank. The request stage reads by 7-bit address from the other bank. Banks swap only at a reader-signalled frame boundary, so a frame never mixes bytes from two captures.

## Interface
Parameters:
- ADDR_W, 7, address width; bank depth = 2^ADDR_W.
- DATA_W, 8, byte width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wrStart  in  1  single-cycle pulse that begins a new capture.
- wrValid  in  1  wrData qualifier.
- wrData  in  DATA_W  sample byte.
- rdAddr  in  ADDR_W  read address from the request stage (its tempAddr).
- rdSwap  in  1  single-cycle pulse at the reader's frame boundary.
- clrErr  in  1  clears the sticky error flags.
- rdData  out  DATA_W  registered read data (the request stage's tempData).
- rdBank  out  1  bank currently presented to the reader.
- dataValid  out  1  at least one swap has occurred since reset.
- pending  out  1  a complete capture is waiting in the write bank.
- wrBusy  out  1  write FSM is in FILL.
- errOvf  out  1  sticky flag: wrValid was seen outside FILL.
- errShort  out  1  sticky flag: wrStart aborted an unfinished capture.

## Operation
- Storage is 2 × 2^ADDR_W × DATA_W. The write bank is always ~rdBank. Memory contents are not reset.
- Write FSM, IDLE state:
  - wrStart: go to FILL, ptr=0, clear pending.
  - If wrValid is also high in the same cycle: write the byte at address 0 and set ptr=1.
  - wrValid without wrStart: drop the byte and set errOvf.
- Write FSM, FILL state:
  - wrValid: write wrData at ptr, then ptr+1.
  - Write at ptr = 2^ADDR_W−1: set pending=1, go to IDLE, ptr wraps to 0.
  - wrStart in FILL: set errShort, ptr=0 (the restart byte is handled as in IDLE), stay in FILL.
- A capture that completes while pending=1 overwrites the previous capture (latest wins). pending is cleared when FILL is entered and re-set when the capture completes.
- Swap:
  - rdSwap with pending=1: toggle rdBank, clear pending, set dataValid.
  - rdSwap with pending=0: ignored.
  - pending=1 implies IDLE, so a swap never exposes a partially written bank.
- Read: rdData <= mem[rdBank][rdAddr] every cycle.
- clrErr clears errOvf and errShort. An error event in the same cycle as clrErr wins: the flag is set.

## Timing
- Reset values: rdData=0, rdBank=0, dataValid=0, pending=0, wrBusy=0, errOvf=0, errShort=0, FSM=IDLE, ptr=0.
- Reset mid-capture discards the capture; the previous read bank is lost as a valid source (dataValid=0).
- Read latency: 1 cycle. rdData in cycle n+1 reflects rdAddr and rdBank sampled in cycle n.
- Swap latency: rdBank changes the cycle after rdSwap. A read issued in the rdSwap cycle still returns old-bank data.
- pending rises the cycle after the final byte is written. rdSwap in the same cycle as that final write is ignored.
- wrBusy is high from the cycle after wrStart until the cycle after the final byte.
- Write throughput: one byte per cycle. Gaps in wrValid are allowed and have no timeout.
- A write and a read never target the same bank in the same cycle, so no read-during-write hazard exists.

## Test plan
- Reset, then capture bytes 0x00..0x7F, then rdSwap → rdBank=1, dataValid=1, pending=0; rdAddr=0x05 → rdData=0x05 one cycle later.
- Second capture 0x80..0xFF while the reader sweeps addresses → reads return the first capture unchanged until rdSwap; after the swap, rdAddr=0x05 → 0x85.
- rdSwap with pending=0, and rdSwap in the final-write cycle → rdBank unchanged; the next rdSwap toggles it.
- wrStart after 40 bytes, then a full 128-byte capture → errShort=1; after the swap, address 0 holds the first byte following the restart.
- wrValid in IDLE → errOvf=1 and no memory change; clrErr together with a new wrValid in IDLE → errOvf stays 1; clrErr alone → 0.
- Reset asserted mid-FILL → all outputs at reset values the next cycle; a new capture plus swap works normally.
